// File: rtl/load_arb_pkg.sv
// rtl/load_arb_pkg.sv - shared FSM encoding and width helper for the load register arbiter
package load_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner select
// Scans i_ptr+1, i_ptr+2, ... modulo N; the first set request wins.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [W-1:0] o_winner,
  output logic         o_any_req
);

  logic [W-1:0] w_idx;

  always_comb begin
    o_winner  = '0;
    o_any_req = 1'b0;
    w_idx     = '0;
    for (int i = 1; i <= N; i++) begin
      w_idx = W'((int'(i_ptr) + i) % N);
      if (!o_any_req && i_req[w_idx]) begin
        o_winner  = w_idx;
        o_any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/load_reg_arbiter.sv
// rtl/load_reg_arbiter.sv - shares one load register between N_REQ requesters
// Define LOAD_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module load_reg_arbiter
  import load_arb_pkg::*;
#(
  parameter int  N_REQ    = 4,
  parameter int  DATA_W   = 4,
  parameter int  HOLD_CYC = 2,
  localparam int IDX_W    = clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] data_in,
  output logic [N_REQ-1:0]        ack,
  output logic                    load,
  output logic [DATA_W-1:0]       data_out,
  output logic [IDX_W-1:0]        grant_id,
  output logic                    busy
);

  localparam logic [3:0] GAP_LAST = (HOLD_CYC > 0) ? 4'(HOLD_CYC - 1) : 4'd0;

  state_t            r_state;
  state_t            w_next_state;
  logic [IDX_W-1:0]  r_grant_id;
  logic [DATA_W-1:0] r_data_out;
  logic [3:0]        r_gap_cnt;
  logic [IDX_W-1:0]  w_ptr;
  logic [IDX_W-1:0]  w_winner;
  logic              w_any_req;
  logic              w_grant;
  logic [DATA_W-1:0] w_data_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign w_data_arr[g] = data_in[g*DATA_W +: DATA_W];
  end

`ifdef LOAD_ARB_FIXED_PRIO_EN
  // Pinning the pointer to the last index makes the scan start at 0.
  assign w_ptr = IDX_W'(N_REQ - 1);
`else
  logic [IDX_W-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr <= IDX_W'(N_REQ - 1);
    end else if (w_grant) begin
      r_ptr <= w_winner;
    end
  end

  assign w_ptr = r_ptr;
`endif

  rr_pick #(
    .N (N_REQ),
    .W (IDX_W)
  ) u_rr_pick (
    .i_req     (req),
    .i_ptr     (w_ptr),
    .o_winner  (w_winner),
    .o_any_req (w_any_req)
  );

  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_grant      = 1'b1;
          w_next_state = ST_LOAD;
        end
      end
      ST_LOAD: w_next_state = (HOLD_CYC > 0) ? ST_GAP : ST_IDLE;
      ST_GAP: begin
        if (r_gap_cnt == GAP_LAST) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_grant_id <= '0;
      r_data_out <= '0;
      r_gap_cnt  <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_grant) begin
        r_grant_id <= w_winner;
        r_data_out <= w_data_arr[w_winner];
      end
      if (r_state == ST_GAP) r_gap_cnt <= r_gap_cnt + 4'd1;
      else                   r_gap_cnt <= '0;
    end
  end

  // load and ack decode straight from the state register, so they stay coincident.
  assign load     = (r_state == ST_LOAD);
  assign ack      = load ? (N_REQ'(1) << r_grant_id) : '0;
  assign busy     = (r_state != ST_IDLE);
  assign data_out = r_data_out;
  assign grant_id = r_grant_id;

endmodule

// File: tb/tb_load_reg_arbiter.sv
// tb/tb_load_reg_arbiter.sv - directed self-checking bench for load_reg_arbiter
module tb_load_reg_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] data_in;
  logic [3:0]  ack;
  logic        load;
  logic [3:0]  data_out;
  logic [1:0]  grant_id;
  logic        busy;

  logic        rst0;
  logic [3:0]  req0;
  logic [15:0] data0;
  logic [3:0]  ack0;
  logic        load0;
  logic [3:0]  dout0;
  logic [1:0]  gid0;
  logic        busy0;

  int checks = 0;
  int errors = 0;

  load_reg_arbiter #(.N_REQ(4), .DATA_W(4), .HOLD_CYC(2)) u_dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in), .ack(ack),
    .load(load), .data_out(data_out), .grant_id(grant_id), .busy(busy)
  );

  load_reg_arbiter #(.N_REQ(4), .DATA_W(4), .HOLD_CYC(0)) u_dut0 (
    .clk(clk), .rst(rst0), .req(req0), .data_in(data0), .ack(ack0),
    .load(load0), .data_out(dout0), .grant_id(gid0), .busy(busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_load();
    int n;
    n = 0;
    tick();
    while (load !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("load_timeout", 32'(load), 32'd1);
  endtask

  initial begin
    logic [3:0] exp_ack;
    rst = 1'b0; rst0 = 1'b0;
    req = '0; req0 = '0;
    data_in = '0; data0 = '0;

    // 1: reset then idle
    tick(); tick();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_load", 32'(load), 32'd0);
    chk("rst_dout", 32'(data_out), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_ack", 32'(ack), 32'd0);
      chk("idle_load", 32'(load), 32'd0);
      chk("idle_dout", 32'(data_out), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end

    // 2: single request from requester 2, then quiet gap
    req = 4'b0100; data_in = 16'h0A00;
    tick();
    chk("t2_load", 32'(load), 32'd1);
    chk("t2_ack", 32'(ack), 32'b0100);
    chk("t2_dout", 32'(data_out), 32'hA);
    chk("t2_gid", 32'(grant_id), 32'd2);
    chk("t2_busy0", 32'(busy), 32'd1);
    req = 4'b0000;
    tick();
    chk("t2_load_gap", 32'(load), 32'd0);
    chk("t2_ack_gap", 32'(ack), 32'd0);
    chk("t2_busy1", 32'(busy), 32'd1);
    chk("t2_dout_hold", 32'(data_out), 32'hA);
    tick();
    chk("t2_busy2", 32'(busy), 32'd1);
    tick();
    chk("t2_busy_end", 32'(busy), 32'd0);

    rst = 1'b0;
    tick();
    rst = 1'b1;
    data_in = 16'h4321;
`ifdef LOAD_ARB_FIXED_PRIO_EN
    // 4: fixed priority starves requester 3
    req = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      wait_load();
      chk("t4_gid", 32'(grant_id), 32'd1);
      chk("t4_ack", 32'(ack), 32'b0010);
    end
    req = 4'b0000;
`else
    // 3: all requesting, round-robin order 0,1,2,3 twice
    for (int r = 0; r < 2; r++) begin
      req = 4'b1111;
      for (int k = 0; k < 4; k++) begin
        wait_load();
        chk("t3_gid", 32'(grant_id), 32'(k));
        chk("t3_ack", 32'(ack), 32'(1 << k));
        chk("t3_dout", 32'(data_out), 32'(k + 1));
        req[k] = 1'b0;
      end
    end
`endif
    tick(); tick(); tick();
    chk("t3_idle", 32'(busy), 32'd0);

    // 5: reset during LOAD aborts the transaction
    req = 4'b0010; data_in = 16'h0050;
    tick();
    chk("t5_load", 32'(load), 32'd1);
    chk("t5_gid", 32'(grant_id), 32'd1);
    chk("t5_dout", 32'(data_out), 32'h5);
    rst = 1'b0;
    req = 4'b0000;
    tick();
    chk("t5_load_abort", 32'(load), 32'd0);
    chk("t5_ack_abort", 32'(ack), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_dout", 32'(data_out), 32'd0);
    chk("t5_gid_rst", 32'(grant_id), 32'd0);
    rst = 1'b1;
    tick();
    chk("t5_ack_after", 32'(ack), 32'd0);
    chk("t5_load_after", 32'(load), 32'd0);

    // 6: HOLD_CYC=0 alternates loads every other cycle
    rst0 = 1'b1; req0 = 4'b0011; data0 = 16'h0021;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c % 2 == 0) exp_ack = ((c / 2) % 2 == 1) ? 4'b0010 : 4'b0001;
      else            exp_ack = 4'b0000;
      chk("t6_load", 32'(load0), 32'((c % 2) == 0));
      chk("t6_ack", 32'(ack0), 32'(exp_ack));
      if (c % 2 == 0) begin
        chk("t6_gid", 32'(gid0), 32'((c / 2) % 2));
        chk("t6_dout", 32'(dout0), 32'((c / 2) % 2 + 1));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
